// File: rtl/alien_pkg.sv
// Shared types and constants for the alien sprite controller: FSM encoding,
// screen geometry, hitEdgeCode bit positions and the per-axis chase step.
package alien_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_HIT    = 2'd2,
        ST_DEAD   = 2'd3
    } alien_state_t;

    localparam int SCREEN_W    = 640;
    localparam int SCREEN_H    = 480;
    localparam int SPRITE_SIZE = 32;
    localparam int X_MAX       = SCREEN_W - SPRITE_SIZE;
    localparam int Y_MAX       = SCREEN_H - SPRITE_SIZE;

    // hitEdgeCode is packed as {Left, Top, Right, Bottom}
    localparam int EDGE_LEFT   = 3;
    localparam int EDGE_TOP    = 2;
    localparam int EDGE_RIGHT  = 1;
    localparam int EDGE_BOTTOM = 0;

    localparam int POS_W  = 11;
    localparam int CALC_W = 12;

    // One axis of the chase: step toward target, snap when closer than a step,
    // hold if the move would head into a blocked edge, then clamp to screen.
    function automatic logic [POS_W-1:0] axis_step(
        input logic [POS_W-1:0] cur,
        input logic [POS_W-1:0] target,
        input logic             blk_pos,
        input logic             blk_neg,
        input int               step,
        input int               max_pos
    );
        logic signed [CALC_W-1:0] cur_s;
        logic signed [CALC_W-1:0] tgt_s;
        logic signed [CALC_W-1:0] diff;
        logic signed [CALC_W-1:0] step_s;
        logic signed [CALC_W-1:0] max_s;
        logic signed [CALC_W-1:0] nxt;
        cur_s  = signed'({1'b0, cur});
        tgt_s  = signed'({1'b0, target});
        step_s = CALC_W'(step);
        max_s  = CALC_W'(max_pos);
        diff   = tgt_s - cur_s;
        if (diff >= step_s)
            nxt = blk_pos ? cur_s : cur_s + step_s;
        else if (diff <= -step_s)
            nxt = blk_neg ? cur_s : cur_s - step_s;
        else if (diff > 0)
            nxt = blk_pos ? cur_s : tgt_s;
        else if (diff < 0)
            nxt = blk_neg ? cur_s : tgt_s;
        else
            nxt = cur_s;
        if (nxt < 0)
            nxt = '0;
        else if (nxt > max_s)
            nxt = max_s;
        return nxt[POS_W-1:0];
    endfunction

endpackage

// File: rtl/alien_frame_timer.sv
// Loadable frame down-counter for the HIT/DEAD dwell times. Decrements on each
// frame tick, saturates at zero; done flags the last frame (count == 1).
module alien_frame_timer
    import alien_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             tick,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             done,
    output logic             phase_next
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load)
            count_d = load_val;
        else if (tick && (count_q != '0))
            count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN)
            count_q <= '0;
        else
            count_q <= count_d;
    end

    assign done       = (count_q == CNT_W'(1));
    // Bit 2 of the upcoming count drives the 4-frame blink phase
    assign phase_next = count_d[2];

endmodule

// File: rtl/alien_controller.sv
// Alien sprite controller: chases the player once per frame, dwells in HIT and
// DEAD on a frame timer, then respawns. Optional HIT blinking: ALIEN_BLINK_EN.
module alien_controller
    import alien_pkg::*;
#(
    parameter int INIT_X      = 304,
    parameter int INIT_Y      = 224,
    parameter int STEP        = 1,
    parameter int HIT_FRAMES  = 32,
    parameter int DEAD_FRAMES = 120
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        startOfFrame,
    input  logic        gameEnable,
    input  logic        collision,
    input  logic [3:0]  hitEdgeCode,
    input  logic        playerHit,
    input  logic [10:0] playerX,
    input  logic [10:0] playerY,
    output logic [10:0] topLeftX,
    output logic [10:0] topLeftY,
    output logic        alienVisible,
    output logic [1:0]  alienState,
    output logic        killPulse
);

    localparam int CNT_MAX = (HIT_FRAMES > DEAD_FRAMES) ? HIT_FRAMES : DEAD_FRAMES;
    localparam int CNT_W   = ($clog2(CNT_MAX + 1) < 3) ? 3 : $clog2(CNT_MAX + 1);

    localparam logic [POS_W-1:0] INIT_X_V = POS_W'(INIT_X);
    localparam logic [POS_W-1:0] INIT_Y_V = POS_W'(INIT_Y);

`ifdef ALIEN_BLINK_EN
    localparam logic BLINK_ON = 1'b1;
`else
    localparam logic BLINK_ON = 1'b0;
`endif

    alien_state_t     state_q, state_d;
    logic [POS_W-1:0] x_q, x_d;
    logic [POS_W-1:0] y_q, y_d;
    logic [3:0]       mask_q, mask_d;
    logic             kill_q, kill_d;
    logic             visible_q, visible_d;

    logic [3:0]       blocked;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic             tmr_done;
    logic             tmr_phase_next;

    alien_frame_timer #(
        .CNT_W(CNT_W)
    ) u_timer (
        .clk       (clk),
        .resetN    (resetN),
        .tick      (startOfFrame),
        .load      (tmr_load),
        .load_val  (tmr_val),
        .done      (tmr_done),
        .phase_next(tmr_phase_next)
    );

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        mask_d    = '0;
        kill_d    = 1'b0;
        visible_d = 1'b0;
        tmr_load  = 1'b0;
        tmr_val   = '0;
        // A collision on the frame-boundary cycle still counts for that frame
        blocked   = mask_q | (collision ? hitEdgeCode : 4'b0000);

        if (!gameEnable) begin
            state_d  = ST_IDLE;
            x_d      = INIT_X_V;
            y_d      = INIT_Y_V;
            tmr_load = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (startOfFrame)
                        state_d = ST_ACTIVE;
                end
                ST_ACTIVE: begin
                    if (playerHit) begin
                        state_d  = ST_HIT;
                        kill_d   = 1'b1;
                        tmr_load = 1'b1;
                        tmr_val  = CNT_W'(HIT_FRAMES);
                    end else if (startOfFrame) begin
                        x_d = axis_step(x_q, playerX, blocked[EDGE_RIGHT],
                                        blocked[EDGE_LEFT], STEP, X_MAX);
                        y_d = axis_step(y_q, playerY, blocked[EDGE_BOTTOM],
                                        blocked[EDGE_TOP], STEP, Y_MAX);
                    end else begin
                        mask_d = blocked;
                    end
                end
                ST_HIT: begin
                    if (startOfFrame && tmr_done) begin
                        state_d  = ST_DEAD;
                        tmr_load = 1'b1;
                        tmr_val  = CNT_W'(DEAD_FRAMES);
                    end
                end
                ST_DEAD: begin
                    if (startOfFrame && tmr_done) begin
                        state_d = ST_ACTIVE;
                        x_d     = INIT_X_V;
                        y_d     = INIT_Y_V;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        case (state_d)
            ST_ACTIVE: visible_d = 1'b1;
            ST_HIT:    visible_d = ~(BLINK_ON & tmr_phase_next);
            default:   visible_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q   <= ST_IDLE;
            x_q       <= INIT_X_V;
            y_q       <= INIT_Y_V;
            mask_q    <= '0;
            kill_q    <= 1'b0;
            visible_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            mask_q    <= mask_d;
            kill_q    <= kill_d;
            visible_q <= visible_d;
        end
    end

    assign topLeftX     = x_q;
    assign topLeftY     = y_q;
    assign alienVisible = visible_q;
    assign alienState   = state_q;
    assign killPulse    = kill_q;

endmodule

// File: tb/tb_alien_controller.sv
// Bench for alien_controller: two instances (STEP=1 and STEP=4) share stimulus
// and are checked every cycle against a frame-level behavioural model.
module tb_alien_controller;

    logic        clk = 1'b0;
    logic        resetN;
    logic        startOfFrame, gameEnable, collision, playerHit;
    logic [3:0]  hitEdgeCode;
    logic [10:0] playerX, playerY;

    logic [10:0] x1, y1, x4, y4;
    logic        vis1, vis4, kill1, kill4;
    logic [1:0]  st1, st4;

    int errors  = 0;
    int checks  = 0;
    int kills1  = 0;
    bit started = 1'b0;

    always #5 clk = ~clk;

    alien_controller dut (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
        .gameEnable(gameEnable), .collision(collision), .hitEdgeCode(hitEdgeCode),
        .playerHit(playerHit), .playerX(playerX), .playerY(playerY),
        .topLeftX(x1), .topLeftY(y1), .alienVisible(vis1),
        .alienState(st1), .killPulse(kill1)
    );

    alien_controller #(.STEP(4)) dut4 (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
        .gameEnable(gameEnable), .collision(collision), .hitEdgeCode(hitEdgeCode),
        .playerHit(playerHit), .playerX(playerX), .playerY(playerY),
        .topLeftX(x4), .topLeftY(y4), .alienVisible(vis4),
        .alienState(st4), .killPulse(kill4)
    );

    // Model: st 0..3 = idle/active/hit/dead, cnt = frames left in hit/dead
    typedef struct packed {
        int st;
        int x;
        int y;
        int cnt;
        int mask;
        bit kill;
    } mdl_t;

    mdl_t m1, m4;

    function automatic mdl_t fresh();
        mdl_t s;
        s.st = 0; s.x = 304; s.y = 224; s.cnt = 0; s.mask = 0; s.kill = 1'b0;
        return s;
    endfunction

    function automatic int chase(int cur, int tgt, int step, bit blk_up, bit blk_down, int hi);
        int d, dir, mag, n;
        d   = tgt - cur;
        dir = (d > 0) ? 1 : ((d < 0) ? -1 : 0);
        mag = (d < 0) ? -d : d;
        if ((dir > 0 && blk_up) || (dir < 0 && blk_down))
            n = cur;
        else if (mag >= step)
            n = cur + dir * step;
        else
            n = tgt;
        if (n < 0)  n = 0;
        if (n > hi) n = hi;
        return n;
    endfunction

    function automatic mdl_t advance(mdl_t s, int step);
        int eff;
        s.kill = 1'b0;
        if (!gameEnable) return fresh();
        eff    = s.mask | (collision ? int'(hitEdgeCode) : 0);
        s.mask = 0;
        case (s.st)
            0: if (startOfFrame) s.st = 1;
            1: begin
                if (playerHit) begin
                    s.st = 2; s.cnt = 32; s.kill = 1'b1;
                end else if (startOfFrame) begin
                    s.x = chase(s.x, int'(playerX), step, eff[1], eff[3], 608);
                    s.y = chase(s.y, int'(playerY), step, eff[0], eff[2], 448);
                end else begin
                    s.mask = eff;
                end
            end
            2: if (startOfFrame) begin
                if (s.cnt == 1) begin s.st = 3; s.cnt = 120; end
                else s.cnt = s.cnt - 1;
            end
            default: if (startOfFrame) begin
                if (s.cnt == 1) begin s.st = 1; s.cnt = 0; s.x = 304; s.y = 224; end
                else s.cnt = s.cnt - 1;
            end
        endcase
        return s;
    endfunction

    function automatic bit visible_of(mdl_t s);
        if (s.st == 1) return 1'b1;
`ifdef ALIEN_BLINK_EN
        if (s.st == 2) return !s.cnt[2];
`else
        if (s.st == 2) return 1'b1;
`endif
        return 1'b0;
    endfunction

    always @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            m1 <= fresh();
            m4 <= fresh();
        end else begin
            m1 <= advance(m1, 1);
            m4 <= advance(m4, 4);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            chk("x_s1",    32'(x1),    32'(m1.x));
            chk("y_s1",    32'(y1),    32'(m1.y));
            chk("st_s1",   32'(st1),   32'(m1.st));
            chk("vis_s1",  32'(vis1),  32'(visible_of(m1)));
            chk("kill_s1", 32'(kill1), 32'(m1.kill));
            chk("x_s4",    32'(x4),    32'(m4.x));
            chk("y_s4",    32'(y4),    32'(m4.y));
            chk("st_s4",   32'(st4),   32'(m4.st));
            chk("vis_s4",  32'(vis4),  32'(visible_of(m4)));
            chk("kill_s4", 32'(kill4), 32'(m4.kill));
            if (kill1 === 1'b1) kills1++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic frame();
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
        repeat (3) tick();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout, expected bench to finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        resetN = 1'b0; startOfFrame = 1'b0; gameEnable = 1'b0; collision = 1'b0;
        playerHit = 1'b0; hitEdgeCode = 4'b0000; playerX = 11'd400; playerY = 11'd224;
        repeat (2) @(posedge clk);
        #1;
        started = 1'b1;
        tick();
        chk("rst_x", 32'(x1), 304);
        chk("rst_y", 32'(y1), 224);
        chk("rst_state", 32'(st1), 0);
        chk("rst_vis", 32'(vis1), 0);
        chk("rst_kill", 32'(kill1), 0);

        // Chase to the right, one pixel per frame
        resetN = 1'b1; gameEnable = 1'b1;
        tick();
        frame();
        chk("activate_state", 32'(st1), 1);
        chk("activate_x", 32'(x1), 304);
        frame(); chk("chase_x1", 32'(x1), 305);
        frame(); chk("chase_x2", 32'(x1), 306);
        frame(); chk("chase_x3", 32'(x1), 307);
        chk("chase_y", 32'(y1), 224);
        chk("chase_vis", 32'(vis1), 1);
        chk("chase_x_step4", 32'(x4), 316);

        // Asynchronous reset, then snap without overshoot at STEP=4
        resetN = 1'b0;
        #2;
        chk("async_rst_state", 32'(st1), 0);
        chk("async_rst_x4", 32'(x4), 304);
        tick();
        resetN = 1'b1;
        tick();
        frame();
        playerX = 11'd305;
        frame();
        chk("snap_x4", 32'(x4), 305);
        chk("snap_x1", 32'(x1), 305);
        frame();
        chk("snap_hold_x4", 32'(x4), 305);

        // Right-edge collision blocks +X for one frame only
        playerX = 11'd400;
        collision = 1'b1; hitEdgeCode = 4'b0010;
        tick();
        collision = 1'b0; hitEdgeCode = 4'b0000;
        tick();
        frame();
        chk("blocked_x1", 32'(x1), 305);
        chk("blocked_x4", 32'(x4), 305);
        frame();
        chk("unblocked_x1", 32'(x1), 306);
        chk("unblocked_x4", 32'(x4), 309);
        collision = 1'b1; hitEdgeCode = 4'b1000;
        tick();
        collision = 1'b0; hitEdgeCode = 4'b0000;
        frame();
        chk("left_flag_x1", 32'(x1), 307);

        // Hit coincident with frame start: hit wins, single killPulse
        playerHit = 1'b1; startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
        chk("hit_kill", 32'(kill1), 1);
        chk("hit_state", 32'(st1), 2);
        chk("hit_no_move", 32'(x1), 307);
        chk("hit_vis", 32'(vis1), 1);
        tick();
        chk("hit_kill_once", 32'(kill1), 0);
        tick();
        playerHit = 1'b0;
        repeat (31) frame();
        chk("hit_dwell_state", 32'(st1), 2);
        frame();
        chk("dead_state", 32'(st1), 3);
        chk("dead_vis", 32'(vis1), 0);
        repeat (119) frame();
        chk("dead_dwell_state", 32'(st1), 3);
        frame();
        chk("respawn_state", 32'(st1), 1);
        chk("respawn_x", 32'(x1), 304);
        chk("respawn_y", 32'(y1), 224);
        chk("kill_count_1", 32'(kills1), 1);

        // gameEnable dropped while DEAD
        playerHit = 1'b1;
        tick();
        playerHit = 1'b0;
        repeat (32) frame();
        chk("dead2_state", 32'(st1), 3);
        repeat (5) frame();
        gameEnable = 1'b0;
        tick();
        chk("disable_state", 32'(st1), 0);
        chk("disable_vis", 32'(vis1), 0);
        chk("disable_x", 32'(x1), 304);
        chk("disable_y", 32'(y1), 224);
        frame();
        chk("disabled_stays_idle", 32'(st1), 0);
        playerHit = 1'b1;
        tick();
        playerHit = 1'b0;
        tick();
        chk("idle_hit_ignored", 32'(kills1), 2);

        // Reset in the middle of HIT
        gameEnable = 1'b1;
        frame();
        playerHit = 1'b1;
        tick();
        playerHit = 1'b0;
        chk("hit3_state", 32'(st1), 2);
        frame();
        resetN = 1'b0;
        #2;
        chk("midhit_rst_state", 32'(st1), 0);
        chk("midhit_rst_vis", 32'(vis1), 0);
        tick();
        resetN = 1'b1;
        tick();
        chk("midhit_rst_kill", 32'(kill1), 0);
        chk("kill_count_3", 32'(kills1), 3);

        // Screen clamping
        frame();
        playerX = 11'd305; playerY = 11'd225;
        frame();
        playerX = 11'd2047; playerY = 11'd2047;
        repeat (160) frame();
        chk("clamp_hi_x4", 32'(x4), 608);
        chk("clamp_hi_y4", 32'(y4), 448);
        chk("far_x1", 32'(x1), 465);
        chk("far_y1", 32'(y1), 385);
        playerX = 11'd0; playerY = 11'd0;
        repeat (160) frame();
        chk("floor_x4", 32'(x4), 0);
        chk("floor_y4", 32'(y4), 0);
        chk("back_x1", 32'(x1), 305);
        chk("back_y1", 32'(y1), 225);

        tick();
        started = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
